// File: rtl/hex_disp_pkg.sv
// Shared types and constants for the multi-channel hex display controller:
// segment type, blank pattern and the active-low hex font.
package hex_disp_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low glyphs indexed by nibble value, bit6=g ... bit0=a.
  localparam seg_t FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_c_o
);

  assign seg_c_o = FONT[nibble_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-channel two-digit hex display driver with per-channel blink and
// leading-zero suppression, plus a shared PWM brightness control.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int unsigned NUM_CH    = 3,
  parameter int unsigned BLINK_DIV = 25_000_000,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [8*NUM_CH-1:0]   data_in,
  input  logic [NUM_CH-1:0]     wr_en,
  input  logic [NUM_CH-1:0]     blink_mask,
  input  logic [NUM_CH-1:0]     lz_en,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [7*NUM_CH-1:0]   led0,
  output logic [7*NUM_CH-1:0]   led1
);

  localparam int unsigned PRESC_W = 32;
  localparam int unsigned LED_W   = SEG_W * NUM_CH;

  logic [7:0]          value_q [NUM_CH];
  seg_t                lo_seg  [NUM_CH];
  seg_t                hi_seg  [NUM_CH];

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [LED_W-1:0]    led0_q, led0_d;
  logic [LED_W-1:0]    led1_q, led1_d;
  logic                pwm_lit;

  // Per-channel value registers; reset wins over any write strobe.
  always_ff @(posedge clk_clk) begin
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (reset_reset) begin
        value_q[i] <= 8'h00;
      end else if (wr_en[i]) begin
        value_q[i] <= data_in[8*i +: 8];
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    hex_seg_decode u_lo (.nibble_i(value_q[g][3:0]), .seg_c_o(lo_seg[g]));
    hex_seg_decode u_hi (.nibble_i(value_q[g][7:4]), .seg_c_o(hi_seg[g]));
  end

  // Shared blink prescaler and PWM counter next-state.
  always_comb begin
    presc_d       = presc_q + PRESC_W'(1);
    blink_phase_d = blink_phase_q;
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
    if (presc_q == PRESC_W'(BLINK_DIV - 1)) begin
      presc_d       = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  assign pwm_lit = (brightness == {PWM_BITS{1'b1}}) || (brightness > pwm_cnt_q);

  // Blank priority: PWM off, then blink, then leading zero, then glyph.
  always_comb begin
    led0_d = {LED_W{1'b1}};
    led1_d = {LED_W{1'b1}};
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (pwm_lit && !(blink_mask[i] && blink_phase_q)) begin
        led0_d[SEG_W*i +: SEG_W] = lo_seg[i];
        if (!(lz_en[i] && (value_q[i][7:4] == 4'h0))) begin
          led1_d[SEG_W*i +: SEG_W] = hi_seg[i];
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc_q       <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      led0_q        <= {LED_W{1'b1}};
      led1_q        <= {LED_W{1'b1}};
    end else begin
      presc_q       <= presc_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      led0_q        <= led0_d;
      led1_q        <= led1_d;
    end
  end

  assign led0 = led0_q;
  assign led1 = led1_q;

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of 8-bit channels; each channel drives two seven-segment digits.
REQ-002 Parameter BLINK_DIV, default 25_000_000: clock cycles per blink half-period; legal range 2..2^32-1.
REQ-003 Parameter PWM_BITS, default 4: brightness resolution; legal range 1..8.
REQ-004 clk_clk  in  1: single clock; all logic rising-edge.
REQ-005 reset_reset  in  1: synchronous, active-high reset.
REQ-006 data_in  in  8*NUM_CH: channel i value at bits [8i+7:8i].
REQ-007 wr_en  in  NUM_CH: per-channel load strobe, one cycle wide.
REQ-008 blink_mask  in  NUM_CH: 1 = channel i blinks.
REQ-009 lz_en  in  NUM_CH: 1 = suppress channel i high digit when its value is 0.
REQ-010 brightness  in  PWM_BITS: global duty level.
REQ-011 led0  out  7*NUM_CH: channel i low-nibble digit at bits [7i+6:7i], active-low, bit0=a ... bit6=g.
REQ-012 led1  out  7*NUM_CH: channel i high-nibble digit, same layout.

Function
REQ-013 Channel i value register SHALL load data_in slice i on the clock edge where wr_en[i]=1; otherwise hold.
REQ-014 Simultaneous wr_en bits SHALL load all flagged channels on the same edge; the channels are independent.
REQ-015 Font: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bit6..bit0); blank=1111111.
REQ-016 led0/led1 SHALL be registered; a load on edge N is visible after edge N+1 (latency 2 edges from wr_en sample).
REQ-017 The blink prescaler SHALL count 0..BLINK_DIV-1, wrap to 0, and toggle blink_phase on wrap.
REQ-018 When blink_mask[i]=1 and blink_phase=1, both digits of channel i SHALL be blank; the value register is unaffected.
REQ-019 When lz_en[i]=1 and the value's high nibble=0, led1 of channel i SHALL be blank; led0 is still shown (value 0x00 shows "0").
REQ-020 The PWM counter (PWM_BITS wide) SHALL increment every cycle and wrap at 2^PWM_BITS-1 to 0.
REQ-021 Segments SHALL be lit when brightness > pwm_cnt; brightness = all-ones SHALL force lit every cycle; brightness=0 SHALL blank all digits.
REQ-022 Blank priority, in order: PWM-off, then blink, then leading-zero, then font.
REQ-023 Changing blink_mask, lz_en or brightness SHALL take effect in led outputs one edge later; no relatch via wr_en is needed.

Reset
REQ-024 While reset_reset=1 at an edge, all value registers SHALL clear to 0x00.
REQ-025 While reset_reset=1 at an edge, led0/led1 SHALL go to all-ones (blank), and the prescaler, blink_phase and pwm_cnt SHALL go to 0.
REQ-026 wr_en SHALL be ignored during reset.
REQ-027 Reset mid-blink or mid-PWM period SHALL restart both counters from 0 on the first non-reset cycle.
REQ-028 The first non-reset edge SHALL produce the normal decode of 0x00, subject to REQ-021.

Structure
REQ-029 Package hex_disp_pkg SHALL hold the seven-bit segment type, the SEG_BLANK constant and the 16-entry font constant table.
REQ-030 Sub-module hex_seg_decode (4-bit nibble in, 7-bit active-low segments out, combinational) SHALL be instantiated 2*NUM_CH times.
REQ-031 The prescaler and PWM counters SHALL be shared by all channels; no per-channel counters.

Verification (NUM_CH=3, BLINK_DIV=4, PWM_BITS=2, brightness=3 unless stated)
REQ-032 Reset, then wr_en=001 with data 0x3A -> two edges later ch0 led1=0110000, led0=0001000; ch1 and ch2 show "00" (1000000 on both digits).
REQ-033 wr_en=111 with data 0xFF_12_07 and lz_en=001 -> ch0 led1 blank, led0=1111000; ch1 shows "12"; ch2 shows "FF".
REQ-034 blink_mask=010 -> ch1 alternates 4 cycles shown / 4 cycles blank; ch0 and ch2 steady.
REQ-035 brightness=1 -> every digit lit 1 of every 4 cycles (when pwm_cnt=0); brightness=0 -> permanently blank.
REQ-036 Assert reset_reset for 1 cycle mid-blink -> all outputs blank at that edge, values 0x00 afterwards, and blink restarts in the visible phase for a full 4 cycles.
